// File: rtl/noun_loader_pkg.sv
// Shared memory-bus constants for the noun loader: widths, function codes,
// loader error codes and the loader state encoding.
package noun_loader_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;

    localparam logic [1:0] GET_CONTENTS = 2'd1;
    localparam logic [1:0] SET_CONTENTS = 2'd2;

    localparam logic [7:0] ERR_NONE       = 8'h00;
    localparam logic [7:0] ERR_OVERFLOW   = 8'h01;
    localparam logic [7:0] ERR_EARLY_WORD = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_WRITE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

endpackage

// File: rtl/noun_loader.sv
// Streams noun words into consecutive memory addresses starting at BASE_ADDR,
// then hands the memory bus to the traversal engine.
module noun_loader
    import noun_loader_pkg::*;
#(
    parameter int                ADDR_W    = MEM_ADDR_W,
    parameter int                DATA_W    = MEM_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    // The all-ones address is the traversal end sentinel, so never write it.
    parameter logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(2 ** ADDR_W - 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic              mem_ready,
    output logic              mux_controller,
    output logic [ADDR_W-1:0] start_addr,
    output logic              execute,
    output logic [ADDR_W:0]   word_count,
    output logic [7:0]        error
);

    state_t state, state_nxt;
    logic   last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (load_start) state_nxt = S_WAIT_WORD;
            S_WAIT_WORD: if (in_valid)   state_nxt = S_WRITE;
            S_WRITE:     state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (mem_ready) begin
                    if (last_q)                    state_nxt = S_DONE;
                    else if (address == MAX_ADDR)  state_nxt = S_ERROR;
                    else                           state_nxt = S_WAIT_WORD;
                end
            end
            S_DONE, S_ERROR: state_nxt = state;
            default:         state_nxt = S_IDLE;
        endcase
    end

    // Bus controls decode straight from state so reset drops them immediately.
    always_comb begin
        in_ready       = 1'b0;
        mem_execute    = 1'b0;
        mem_func       = 2'd0;
        mux_controller = 1'b0;
        execute        = 1'b0;
        case (state)
            S_WAIT_WORD: begin
                in_ready       = 1'b1;
                mux_controller = 1'b1;
            end
            S_WRITE: begin
                mem_execute    = 1'b1;
                mem_func       = SET_CONTENTS;
                mux_controller = 1'b1;
            end
            S_WAIT_ACK: mux_controller = 1'b1;
            S_ERROR:    mux_controller = 1'b1;
            S_DONE:     execute        = 1'b1;
            default: ;
        endcase
    end

    assign start_addr = BASE_ADDR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address    <= BASE_ADDR;
            write_data <= '0;
            last_q     <= 1'b0;
            word_count <= '0;
            error      <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        address    <= BASE_ADDR;
                        word_count <= '0;
                        error      <= ERR_NONE;
                    end else if (in_valid) begin
                        error <= ERR_EARLY_WORD;
                    end
                end
                S_WAIT_WORD: begin
                    if (in_valid) begin
                        write_data <= in_data;
                        last_q     <= in_last;
                    end
                end
                S_WAIT_ACK: begin
                    if (mem_ready) begin
                        word_count <= word_count + (ADDR_W + 1)'(1);
                        if (!last_q) begin
                            if (address == MAX_ADDR) error   <= ERR_OVERFLOW;
                            else                     address <= address + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noun_loader.sv
// Randomized bench for noun_loader: a memory responder records every write
// strobe and a queue-based model of the expected address/data sequence checks it.
`timescale 1ns/1ps
module tb_noun_loader;
    import noun_loader_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0, rst = 1'b0;
    logic          load_start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          resp_ready = 1'b0, stray = 1'b0, tie_ready = 1'b0;
    logic          mem_ready;
    logic          in_ready, mem_execute, mux_controller, execute;
    logic [1:0]    mem_func;
    logic [AW-1:0] address, start_addr;
    logic [DW-1:0] write_data;
    logic [AW:0]   word_count;
    logic [7:0]    error;

    assign mem_ready = resp_ready | stray | tie_ready;

    noun_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_execute(mem_execute), .mem_func(mem_func), .address(address),
        .write_data(write_data), .mem_ready(mem_ready),
        .mux_controller(mux_controller), .start_addr(start_addr),
        .execute(execute), .word_count(word_count), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder / strobe monitor state
    logic [AW-1:0] st_addr[$];
    logic [DW-1:0] st_data[$];
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    int  resp_delay = 0, cnt = 0, hold_err = 0, func_err = 0, own_err = 0;
    bit  busy = 0, wrote_top = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        tick();
        resp_ready = 1'b0;
        if (execute && mux_controller) own_err++;
        if (!mem_execute && mem_func !== 2'd0) func_err++;
        if (rst) busy = 0;
        else begin
            if (busy) begin
                if (cnt == 0) begin
                    resp_ready = 1'b1;
                    busy = 0;
                    if (address !== last_addr || write_data !== last_data) hold_err++;
                end else cnt--;
            end
            if (mem_execute) begin
                st_addr.push_back(address);
                st_data.push_back(write_data);
                if (mem_func !== SET_CONTENTS) func_err++;
                if (address == '1) wrote_top = 1;
                last_addr = address;
                last_data = write_data;
                busy = 1;
                cnt  = resp_delay;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; load_start = 1'b0; tie_ready = 1'b0; stray = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, output int acc);
        in_valid = 1'b1; in_data = d; in_last = last;
        acc = -1;
        for (int t = 0; !in_ready; t++) begin
            if (t > 200) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        acc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    // Model: word i of a load goes to BASE+i with its own data; the load ends
    // in DONE with word_count=n, or in ERROR when the stream has no last.
    task automatic run_load(input int n, input bit has_last, input int dly,
                            input int max_gap, input bit chk_rate, input string tag);
        logic [DW-1:0] exp_d[$];
        logic [DW-1:0] d;
        int acc, prev_acc, bad_addr, bad_data, bad_rate;
        bad_addr = 0; bad_data = 0; bad_rate = 0; prev_acc = 0;
        st_addr.delete(); st_data.delete();
        start_load();
        chk({tag, "_start_mux"}, mux_controller, 1);
        chk({tag, "_start_err"}, error, ERR_NONE);
        chk({tag, "_start_cnt"}, word_count, 0);
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            exp_d.push_back(d);
            resp_delay = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
            send_word(d, has_last && (i == n - 1), acc);
            if (i > 0 && acc - prev_acc != 3) bad_rate++;
            prev_acc = acc;
        end
        for (int t = 0; t < 60 && !execute && error == ERR_NONE; t++) tick();
        tick();
        chk({tag, "_nwrites"}, st_addr.size(), n);
        for (int i = 0; i < n && i < st_addr.size(); i++) begin
            if (st_addr[i] !== AW'(i)) bad_addr++;
            if (st_data[i] !== exp_d[i]) bad_data++;
        end
        chk({tag, "_addr_seq"}, bad_addr, 0);
        chk({tag, "_data_seq"}, bad_data, 0);
        if (chk_rate) chk({tag, "_rate3"}, bad_rate, 0);
        chk({tag, "_word_count"}, word_count, n);
        chk({tag, "_in_ready_end"}, in_ready, 0);
        if (has_last) begin
            chk({tag, "_execute"}, execute, 1);
            chk({tag, "_mux_off"}, mux_controller, 0);
            chk({tag, "_start_addr"}, start_addr, 0);
            chk({tag, "_err_none"}, error, ERR_NONE);
        end else begin
            chk({tag, "_err_ovf"}, error, ERR_OVERFLOW);
            chk({tag, "_mux_err"}, mux_controller, 1);
            chk({tag, "_exec_err"}, execute, 0);
        end
    endtask

    initial begin
        int acc;
        logic [DW-1:0] d;

        // Reset state while rst is held
        rst = 1'b1;
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_exec", mem_execute, 0);
        chk("rst_mem_func", mem_func, 0);
        chk("rst_address", address, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_mux", mux_controller, 0);
        chk("rst_start_addr", start_addr, 0);
        chk("rst_execute", execute, 0);
        chk("rst_wcount", word_count, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        tick();

        // Three words, ack two cycles after each strobe
        run_load(3, 1, 2, 0, 0, "basic");
        load_start = 1'b1; tick(); load_start = 1'b0;
        tick(); tick();
        chk("done_ignore_ls_exec", execute, 1);
        chk("done_ignore_ls_cnt", word_count, 3);
        chk("done_ignore_ls_nwr", st_addr.size(), 3);

        // Back-to-back stream with mem_ready tied high
        do_reset();
        tie_ready = 1'b1;
        run_load(int'($urandom_range(5, 12)), 1, 0, 0, 1, "stream");
        tie_ready = 1'b0;

        // Randomized loads: random sizes, ack delays and input gaps
        for (int k = 0; k < 4; k++) begin
            do_reset();
            run_load(int'($urandom_range(1, 8)), 1, -1, 3, 0, "rand");
        end

        // Stream word before load_start
        do_reset();
        st_addr.delete();
        in_valid = 1'b1; in_data = $urandom;
        tick(); tick();
        chk("early_error", error, ERR_EARLY_WORD);
        chk("early_in_ready", in_ready, 0);
        chk("early_mux", mux_controller, 0);
        in_valid = 1'b0;
        tick(); tick();
        chk("early_no_strobe", st_addr.size(), 0);
        run_load(2, 1, 1, 1, 0, "after_early");

        // Reset during WAIT_ACK of the second word
        do_reset();
        start_load();
        resp_delay = 0;
        d = $urandom; send_word(d, 1'b0, acc);
        resp_delay = 30;
        d = $urandom; send_word(d, 1'b0, acc);
        tick();
        chk("wack_mux", mux_controller, 1);
        chk("wack_addr", address, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_mem_exec", mem_execute, 0);
        chk("async_mux", mux_controller, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_address", address, 0);
        chk("async_wcount", word_count, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        run_load(4, 1, -1, 2, 0, "after_rst");

        // Stray mem_ready while waiting for a word
        do_reset();
        start_load();
        resp_delay = 0;
        d = $urandom; send_word(d, 1'b0, acc);
        for (int t = 0; t < 20 && !in_ready; t++) tick();
        stray = 1'b1; tick(); stray = 1'b0; tick();
        chk("stray_address", address, 1);
        chk("stray_wcount", word_count, 1);
        chk("stray_in_ready", in_ready, 1);
        d = $urandom; send_word(d, 1'b1, acc);
        for (int t = 0; t < 20 && !execute; t++) tick();
        chk("stray_done_cnt", word_count, 2);

        // Overflow: 1023 words without last fill 0..1022 then ERROR
        do_reset();
        wrote_top = 0;
        run_load(1023, 0, 0, 0, 0, "ovf");
        in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
        repeat (10) tick();
        in_valid = 1'b0;
        chk("ovf_stuck_nwr", st_addr.size(), 1023);
        chk("ovf_stuck_err", error, ERR_OVERFLOW);
        chk("ovf_sentinel", wrote_top, 0);

        chk("hold_during_ack", hold_err, 0);
        chk("mem_func_rule", func_err, 0);
        chk("exec_excl_mux", own_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/noun_loader.md
NOUN_LOADER -- requirements
Module: noun_loader

Interface
REQ-001 Parameter ADDR_W, default `memory_addr_width (10): memory address width.
REQ-002 Parameter DATA_W, default `memory_data_width: memory word width.
REQ-003 Parameter BASE_ADDR, default 0: first address written; also the traversal start address.
REQ-004 Parameter MAX_ADDR, default 1022: last writable address; 1023 is the traversal end sentinel and is never written.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 load_start  in  1  one-cycle pulse; starts a load from IDLE.
REQ-009 in_valid  in  1  stream word valid.
REQ-010 in_ready  out  1  loader accepts a word this cycle.
REQ-011 in_data  in  DATA_W  noun word {tag, hed, tel}, passed to memory unchanged.
REQ-012 in_last  in  1  final word of the noun; qualified by in_valid.
REQ-013 mem_execute  out  1  memory request strobe.
REQ-014 mem_func  out  2  memory function; `SET_CONTENTS while a request is pending, otherwise 0.
REQ-015 address  out  ADDR_W  memory address.
REQ-016 write_data  out  DATA_W  memory write word.
REQ-017 mem_ready  in  1  memory completion.
REQ-018 mux_controller  out  1  1 = loader owns the memory bus; 0 = traversal owns it.
REQ-019 start_addr  out  ADDR_W  traversal start address.
REQ-020 execute  out  1  level enable to traversal.
REQ-021 word_count  out  ADDR_W+1  words committed in the current load.
REQ-022 error  out  8  0 = none; 8'h01 = overflow; 8'h02 = stream word before load_start.

Function
REQ-023 The state machine SHALL have states IDLE, WAIT_WORD, WRITE, WAIT_ACK, DONE and ERROR.
REQ-024 IDLE: load_start SHALL move to WAIT_WORD, set address to BASE_ADDR, clear word_count and error, and drive mux_controller=1.
REQ-025 IDLE with in_valid=1 and load_start=0: SHALL set error=8'h02 and stay in IDLE; the word is not accepted.
REQ-026 in_ready SHALL be 1 only in WAIT_WORD; a word is accepted on in_valid&in_ready.
REQ-027 On accept: in_data SHALL be latched into write_data, in_last latched internally, next state WRITE.
REQ-028 WRITE: mem_execute=1 and mem_func=`SET_CONTENTS SHALL be driven for exactly one cycle, next state WAIT_ACK.
REQ-029 WAIT_ACK: mem_execute=0 and mem_func=0 each cycle; address and write_data SHALL be held until mem_ready.
REQ-030 On mem_ready in WAIT_ACK: word_count SHALL increment by 1.
REQ-031 If the latched last is 1, next state SHALL be DONE.
REQ-032 Else if address==MAX_ADDR, SHALL set error=8'h01 and go to ERROR.
REQ-033 Otherwise address SHALL increment by 1 and next state is WAIT_WORD.
REQ-034 Minimum latency per word SHALL be 3 cycles (accept, WRITE, WAIT_ACK with mem_ready already high).
REQ-035 mem_ready outside WAIT_ACK SHALL be ignored.
REQ-036 DONE: mux_controller=0, start_addr=BASE_ADDR, execute=1, held until reset; load_start SHALL be ignored.
REQ-037 ERROR: mux_controller=1, execute=0, in_ready=0; SHALL be left only by reset.
REQ-038 load_start outside IDLE SHALL be ignored.
REQ-039 execute SHALL never be 1 while mux_controller is 1.

Reset
REQ-040 On rst=1, asynchronously: state IDLE, all outputs 0, except start_addr=BASE_ADDR and address=BASE_ADDR.
REQ-041 Reset mid-load SHALL abort any pending memory request (execute and mem_execute fall in the same cycle); words already written are not cleared.

Structure
REQ-042 Memory function codes (`GET_CONTENTS, `SET_CONTENTS), width macros and error codes SHALL come from shared memory_unit.vh / mem_traversal.vh; the loader error codes SHALL be added there.
REQ-043 The design SHALL be a single module with no sub-modules; state encoding SHALL be 3 bits with local parameters.

Verification
REQ-044 Scenario: reset, then load_start, then 3 words (last on word 3), mem_ready 2 cycles after each strobe -> writes to addresses 0, 1, 2; word_count=3; DONE with execute=1, mux_controller=0, start_addr=0.
REQ-045 Scenario: in_valid held high, mem_ready tied 1 -> one word every 3 cycles; mem_execute high exactly 1 cycle per word.
REQ-046 Scenario: BASE_ADDR=1020, 4 words with no in_last -> writes to 1020, 1021, 1022; error=8'h01; ERROR state; address 1023 never written.
REQ-047 Scenario: in_valid before load_start -> error=8'h02, in_ready=0, no memory strobe.
REQ-048 Scenario: rst asserted during WAIT_ACK -> mem_execute=0, mux_controller=0 and state IDLE asynchronously; a new load then completes correctly.
REQ-049 Scenario: stray mem_ready pulse in WAIT_WORD -> no word_count or address change.
